interval_counter: RTL

Parametrised tick counter for stream-based designs such as the speedometer. It divides `clk` down to a tick of `DIVISOR` cycles and increments a `WIDTH`-bit counter that wraps at `WRAP`. Each new count is offered on a stb/ack output stream. Compared with the fixed seconds counter, it adds enable, synchronous clear, wrap-around, a latest-value pending mechanism under backpressure, and a sticky overrun flag.

---
 rtl/interval_counter_if.sv | 20 ++
 rtl/interval_counter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/interval_counter_if.sv
// Count output stream of interval_counter: value with a stb/ack handshake.
interface interval_counter_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] output_count;
    logic             output_count_stb;
    logic             output_count_ack;

    modport master (
        output output_count,
        output output_count_stb,
        input  output_count_ack
    );

    modport slave (
        input  output_count,
        input  output_count_stb,
        output output_count_ack
    );
endinterface

// File: rtl/interval_counter.sv
// Prescaled tick counter with wrap, clear, enable and a stb/ack output stream
// that keeps only the latest value under backpressure and flags skipped values.
module interval_counter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DIVISOR = 50000000,
    parameter int unsigned WRAP    = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                clear,
    interval_counter_if.master  bus,
    output logic                overrun,
    output logic [WIDTH-1:0]    count_value
);

    localparam int unsigned      PW         = $clog2(DIVISOR + 1);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(DIVISOR - 1);
    localparam logic [WIDTH-1:0] WRAP_VAL   = WIDTH'(WRAP);

    if (DIVISOR < 1 || WRAP < 1 || (WIDTH < 32 && WRAP > ((32'd1 << WIDTH) - 32'd1))) begin : g_bad_params
        $error("interval_counter: DIVISOR must be >= 1 and WRAP must fit in 1..2^WIDTH-1");
    end

    typedef enum logic {
        S_IDLE,
        S_PRESENT
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             stb_q, stb_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             tick_c;
    logic             xfer_c;

    // Tick is suppressed by clear so a clearing cycle never produces a count.
    always_comb begin
        tick_c = enable && !clear && (presc_q == PRESC_LAST);
        xfer_c = stb_q && bus.output_count_ack;
    end

    // Prescaler and wrapping counter.
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        if (clear) begin
            presc_d = '0;
            count_d = '0;
        end else if (enable) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
            if (tick_c) begin
                count_d = (count_q == WRAP_VAL) ? '0 : count_q + WIDTH'(1);
            end
        end
    end

    // Output stream FSM; count_d is the latest value, including a same-cycle tick.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        stb_d     = stb_q;
        pending_d = pending_q;
        overrun_d = overrun_q;

        unique case (state_q)
            S_IDLE: begin
                if (tick_c) begin
                    out_d   = count_d;
                    stb_d   = 1'b1;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (xfer_c) begin
                    pending_d = 1'b0;
                    if ((pending_q && !clear) || tick_c) begin
                        out_d = count_d;
                    end else begin
                        stb_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (tick_c) begin
                    if (pending_q) begin
                        overrun_d = 1'b1;
                    end
                    pending_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                stb_d   = 1'b0;
            end
        endcase

        // Clear never aborts a presentation in flight, only the bookkeeping.
        if (clear) begin
            pending_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            out_q     <= '0;
            stb_q     <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            out_q     <= out_d;
            stb_q     <= stb_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.output_count     = out_q;
    assign bus.output_count_stb = stb_q;
    assign overrun              = overrun_q;
    assign count_value          = count_q;

endmodule
